sdram_cmd_checker: RTL
======================

Name: sdram_cmd_checker

Overview:
- Whitebox protocol checker for the SDRAM controller verification environment.
- Passively samples the SDRAM command bus (cs_n/ras_n/cas_n/we_n, bank, address) and tracks per-bank open/idle state.
- Enforces tRCD, tRP, tRFC and refresh-interval rules, reports the first violation each cycle, and keeps saturating command counters.
- Parametrised in bank count, address width and every timing value; instantiated alongside the whitebox interface and driven from the same signals.

Parameters:
- NUM_BANKS, 4, number of SDRAM banks (power of two, >=2); BA_W = $clog2(NUM_BANKS) is derived.
- ROW_W, 12, width of sdram_addr; must be >=11 because A10 is the precharge-all bit.
- T_RCD, 3, minimum cycles from ACT to READ/WRITE on the same bank.
- T_RP, 3, minimum cycles from PRE to ACT on the same bank.
- T_RFC, 7, minimum cycles from REF to any non-NOP command.
- T_REFI, 1560, maximum cycles between REF commands.
- CNT_W, 16, width of the command counters.

Ports:
- sdram_clk  in  1  sampling clock.
- sdram_rst  in  1  asynchronous, active-low reset.
- mon_en  in  1  checking enable.
- clr_i  in  1  synchronous clear of the counters and the sticky error flags.
- sdram_cs_n  in  1  chip select, active low.
- sdram_ras_n  in  1  row address strobe, active low.
- sdram_cas_n  in  1  column address strobe, active low.
- sdram_we_n  in  1  write enable, active low.
- sdram_ba  in  BA_W  bank address.
- sdram_addr  in  ROW_W  row/column address; bit 10 selects precharge-all.
- bank_open_o  out  NUM_BANKS  per-bank open flag.
- err_valid_o  out  1  one-cycle violation pulse.
- err_code_o  out  3  violation code.
- err_bank_o  out  BA_W  bank of the violating command.
- err_sticky_o  out  8  bit n set once code n has fired.
- act_cnt_o  out  CNT_W  ACT command count.
- rd_cnt_o  out  CNT_W  READ command count.
- wr_cnt_o  out  CNT_W  WRITE command count.
- ref_cnt_o  out  CNT_W  REF command count.

Behaviour:
- Reset (sdram_rst=0, asynchronous): all outputs 0, all banks idle, all timers 0, refresh-interval timer 0.
- Decode {ras_n,cas_n,we_n}, only when cs_n=0 and mon_en=1:
  - 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS, 110 BST, 111 NOP.
  - cs_n=1 or mon_en=0 is treated as NOP.
- Per-bank state (IDLE/ACTIVE) and a down-timer that decrements to 0 and saturates there:
  - ACT: bank becomes ACTIVE, timer loads T_RCD.
  - PRE with A10=0: target bank becomes IDLE, timer loads T_RP.
  - PRE with A10=1: all banks become IDLE, all timers load T_RP.
  - PRE to an already-idle bank is legal.
- Timing rule: a command at edge t0 permits the dependent command at t0+k only when k >= T_RCD (or T_RP, or T_RFC).
- Global rfc down-timer loads T_RFC on REF. The refresh-interval counter clears on REF and otherwise counts up, saturating at T_REFI.
- Violation codes, one command per cycle, reported in priority order:
  - 6 TRFC: any non-NOP command while the rfc timer is nonzero.
  - 1 ACT_OPEN: ACT to an ACTIVE bank.
  - 4 TRP: ACT while the bank timer is nonzero.
  - 2 RW_IDLE: READ/WRITE to an IDLE bank.
  - 3 TRCD: READ/WRITE while the bank timer is nonzero.
  - 5 REF_OPEN: REF while any bank is ACTIVE.
  - 7 REFI: refresh-interval counter reaches T_REFI. Pulses once and re-arms on the next REF. On a collision with a command error, only the sticky bit records it.
  - 0: none.
- Latency: err_valid_o/err_code_o/err_bank_o are registered and appear 1 cycle after the sampled command. err_bank_o is 0 for codes 5, 6 and 7.
- State updates apply even when the command is illegal, so the checker tracks the DUT as-is.
  - Example: ACT to an open bank reloads T_RCD and the bank stays ACTIVE.
- Counters:
  - Increment on the decoded command and saturate at all-ones.
  - clr_i zeroes counters and err_sticky_o only; bank state and timers are unaffected.
  - clr_i coincident with a command: the clear wins for that cycle's increment, but a sticky bit set by that command still sets.
- mon_en=0: timers keep decrementing; the refresh-interval counter holds at 0.
- Reset asserted mid-operation returns everything to the reset values immediately.

Decomposition:
- Package sdram_chk_pkg:
  - cmd_e enum of the 8 commands.
  - err_e enum of codes 0-7.
  - decode_cmd function.
  - ERR_W=3 constant.
- Sub-module sdram_bank_tracker holds one bank's state and timer. It is generated NUM_BANKS times and outputs open/timer_zero flags to the top-level priority encoder.

Test Plan:
- ACT bank1 at t0, READ bank1 at t0+3 (defaults) -> no error, bank_open_o=4'b0010, act_cnt=1, rd_cnt=1.
- ACT bank0 at t0, WRITE bank0 at t0+2 -> err_valid pulse at t0+3, code 3, bank 0, err_sticky_o[3]=1.
- PRE with A10=1 at t0, ACT bank2 at t0+1 -> code 4, bank 2. A second ACT bank2 at t0+4 -> code 1.
- ACT bank3, then REF with no PRE -> code 5. Then MRS 2 cycles after the REF -> code 6.
- No REF for 1560 cycles after reset -> single code-7 pulse. REF, then another 1560 idle cycles -> second pulse.
- 65540 ACT/PRE pairs -> act_cnt saturates at 16'hFFFF. clr_i -> counters 0, sticky 0, bank_open_o retained. Async reset mid-burst -> all outputs 0.

Source files
------------

// File: rtl/sdram_chk_pkg.sv
// Shared types and helpers for the SDRAM command-bus protocol checker.
package sdram_chk_pkg;

   localparam int unsigned ERR_W = 3;

   typedef enum logic [2:0] {
      CmdMrs = 3'b000,
      CmdRef = 3'b001,
      CmdPre = 3'b010,
      CmdAct = 3'b011,
      CmdWr  = 3'b100,
      CmdRd  = 3'b101,
      CmdBst = 3'b110,
      CmdNop = 3'b111
   } cmd_e;

   typedef enum logic [ERR_W-1:0] {
      ErrNone    = 3'd0,
      ErrActOpen = 3'd1,
      ErrRwIdle  = 3'd2,
      ErrTrcd    = 3'd3,
      ErrTrp     = 3'd4,
      ErrRefOpen = 3'd5,
      ErrTrfc    = 3'd6,
      ErrRefi    = 3'd7
   } err_e;

   function automatic cmd_e decode_cmd(input logic en, input logic cs_n, input logic ras_n,
                                       input logic cas_n, input logic we_n);
      if (!en || cs_n) return CmdNop;
      return cmd_e'({ras_n, cas_n, we_n});
   endfunction

   // Timers load t-1 so that a zero reading at edge t0+k means k >= t.
   function automatic int unsigned tmr_load(input int unsigned t);
      return (t == 0) ? 0 : t - 1;
   endfunction

   function automatic int unsigned tmr_w(input int unsigned t);
      return (t < 2) ? 1 : $clog2(t);
   endfunction

endpackage

// File: rtl/sdram_cmd_checker_if.sv
// SDRAM command bus as seen by the checker; master drives, slave observes.
interface sdram_cmd_checker_if #(
   parameter int unsigned NUM_BANKS = 4,
   parameter int unsigned ROW_W     = 12
);
   localparam int unsigned BA_W = $clog2(NUM_BANKS);

   logic             sdram_cs_n;
   logic             sdram_ras_n;
   logic             sdram_cas_n;
   logic             sdram_we_n;
   logic [BA_W-1:0]  sdram_ba;
   logic [ROW_W-1:0] sdram_addr;

   modport master (
      output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
   );

   modport slave (
      input sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
   );

endinterface

// File: rtl/sdram_bank_tracker.sv
// One bank's IDLE/ACTIVE state plus its tRCD/tRP down-timer.
module sdram_bank_tracker #(
   parameter int unsigned TMR_W  = 2,
   parameter int unsigned RCD_LD = 2,
   parameter int unsigned RP_LD  = 2
) (
   input  logic sdram_clk,
   input  logic sdram_rst,
   input  logic i_act,
   input  logic i_pre,
   output logic o_open,
   output logic o_tmr_zero
);

   logic             r_open;
   logic [TMR_W-1:0] r_tmr;

   always_ff @(posedge sdram_clk or negedge sdram_rst) begin
      if (!sdram_rst) begin
         r_open <= 1'b0;
         r_tmr  <= '0;
      end else if (i_act) begin
         r_open <= 1'b1;
         r_tmr  <= TMR_W'(RCD_LD);
      end else if (i_pre) begin
         r_open <= 1'b0;
         r_tmr  <= TMR_W'(RP_LD);
      end else if (r_tmr != '0) begin
         r_tmr <= r_tmr - 1'b1;
      end
   end

   assign o_open     = r_open;
   assign o_tmr_zero = (r_tmr == '0);

endmodule

// File: rtl/sdram_cmd_checker.sv
// Passive SDRAM command-bus checker: bank tracking, timing rules, refresh interval,
// prioritised violation reporting and saturating command counters.
module sdram_cmd_checker
   import sdram_chk_pkg::*;
#(
   parameter int unsigned NUM_BANKS = 4,
   parameter int unsigned ROW_W     = 12,
   parameter int unsigned T_RCD     = 3,
   parameter int unsigned T_RP      = 3,
   parameter int unsigned T_RFC     = 7,
   parameter int unsigned T_REFI    = 1560,
   parameter int unsigned CNT_W     = 16,
   localparam int unsigned BA_W     = $clog2(NUM_BANKS)
) (
   input  logic                 sdram_clk,
   input  logic                 sdram_rst,
   input  logic                 mon_en,
   input  logic                 clr_i,
   sdram_cmd_checker_if.slave   i_cmd_bus,
   output logic [NUM_BANKS-1:0] bank_open_o,
   output logic                 err_valid_o,
   output logic [ERR_W-1:0]     err_code_o,
   output logic [BA_W-1:0]      err_bank_o,
   output logic [7:0]           err_sticky_o,
   output logic [CNT_W-1:0]     act_cnt_o,
   output logic [CNT_W-1:0]     rd_cnt_o,
   output logic [CNT_W-1:0]     wr_cnt_o,
   output logic [CNT_W-1:0]     ref_cnt_o
);

   localparam int unsigned BANK_TW = tmr_w((T_RCD > T_RP) ? T_RCD : T_RP);
   localparam int unsigned RFC_W   = tmr_w(T_RFC);
   localparam int unsigned REFI_W  = $clog2(T_REFI + 1);

   cmd_e                 w_cmd;
   logic                 w_is_act, w_is_pre, w_is_rw, w_is_ref;
   logic [NUM_BANKS-1:0] w_act_vec, w_pre_vec, w_open, w_tmr_zero;
   logic [BA_W-1:0]      w_ba;
   err_e                 w_err;
   logic [BA_W-1:0]      w_err_bank;
   logic                 w_refi_hit;
   logic                 w_valid;
   logic [ERR_W-1:0]     w_code;
   logic [7:0]           w_sticky_set;
   logic                 w_unused_addr;

   logic [RFC_W-1:0]     r_rfc;
   logic [REFI_W-1:0]    r_refi;
   logic                 r_err_valid;
   logic [ERR_W-1:0]     r_err_code;
   logic [BA_W-1:0]      r_err_bank;
   logic [7:0]           r_sticky;
   logic [CNT_W-1:0]     r_act_cnt, r_rd_cnt, r_wr_cnt, r_ref_cnt;

   assign w_cmd = decode_cmd(mon_en, i_cmd_bus.sdram_cs_n, i_cmd_bus.sdram_ras_n,
                             i_cmd_bus.sdram_cas_n, i_cmd_bus.sdram_we_n);
   assign w_ba     = i_cmd_bus.sdram_ba;
   assign w_is_act = (w_cmd == CmdAct);
   assign w_is_pre = (w_cmd == CmdPre);
   assign w_is_rw  = (w_cmd == CmdRd) || (w_cmd == CmdWr);
   assign w_is_ref = (w_cmd == CmdRef);
   assign w_unused_addr = ^(i_cmd_bus.sdram_addr & ~(ROW_W'(1) << 10));

   always_comb begin
      w_act_vec = '0;
      w_pre_vec = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         w_act_vec[b] = w_is_act && (w_ba == BA_W'(b));
         w_pre_vec[b] = w_is_pre && (i_cmd_bus.sdram_addr[10] || (w_ba == BA_W'(b)));
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      sdram_bank_tracker #(
         .TMR_W  (BANK_TW),
         .RCD_LD (tmr_load(T_RCD)),
         .RP_LD  (tmr_load(T_RP))
      ) u_bank (
         .sdram_clk  (sdram_clk),
         .sdram_rst  (sdram_rst),
         .i_act      (w_act_vec[b]),
         .i_pre      (w_pre_vec[b]),
         .o_open     (w_open[b]),
         .o_tmr_zero (w_tmr_zero[b])
      );
   end

   always_comb begin
      w_err      = ErrNone;
      w_err_bank = '0;
      if (w_cmd != CmdNop && r_rfc != '0) begin
         w_err = ErrTrfc;
      end else if (w_is_act && w_open[w_ba]) begin
         w_err      = ErrActOpen;
         w_err_bank = w_ba;
      end else if (w_is_act && !w_tmr_zero[w_ba]) begin
         w_err      = ErrTrp;
         w_err_bank = w_ba;
      end else if (w_is_rw && !w_open[w_ba]) begin
         w_err      = ErrRwIdle;
         w_err_bank = w_ba;
      end else if (w_is_rw && !w_tmr_zero[w_ba]) begin
         w_err      = ErrTrcd;
         w_err_bank = w_ba;
      end else if (w_is_ref && (|w_open)) begin
         w_err = ErrRefOpen;
      end
   end

   // Counter saturates at T_REFI, so the hit fires once until a REF clears it.
   assign w_refi_hit = mon_en && !w_is_ref && (r_refi == REFI_W'(T_REFI - 1));

   always_comb begin
      w_valid      = (w_err != ErrNone);
      w_code       = w_err;
      w_sticky_set = '0;
      if (w_err != ErrNone) w_sticky_set[w_err] = 1'b1;
      if (w_refi_hit) begin
         w_sticky_set[ErrRefi] = 1'b1;
         if (!w_valid) begin
            w_valid = 1'b1;
            w_code  = ErrRefi;
         end
      end
   end

   always_ff @(posedge sdram_clk or negedge sdram_rst) begin
      if (!sdram_rst) begin
         r_rfc       <= '0;
         r_refi      <= '0;
         r_err_valid <= 1'b0;
         r_err_code  <= '0;
         r_err_bank  <= '0;
         r_sticky    <= '0;
         r_act_cnt   <= '0;
         r_rd_cnt    <= '0;
         r_wr_cnt    <= '0;
         r_ref_cnt   <= '0;
      end else begin
         if (w_is_ref)          r_rfc <= RFC_W'(tmr_load(T_RFC));
         else if (r_rfc != '0)  r_rfc <= r_rfc - 1'b1;

         if (!mon_en || w_is_ref)               r_refi <= '0;
         else if (r_refi != REFI_W'(T_REFI))    r_refi <= r_refi + 1'b1;

         r_err_valid <= w_valid;
         r_err_code  <= w_code;
         r_err_bank  <= w_err_bank;
         r_sticky    <= (clr_i ? 8'h00 : r_sticky) | w_sticky_set;

         if (clr_i) begin
            r_act_cnt <= '0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_ref_cnt <= '0;
         end else begin
            if (w_is_act && r_act_cnt != '1)          r_act_cnt <= r_act_cnt + 1'b1;
            if (w_cmd == CmdRd && r_rd_cnt != '1)     r_rd_cnt  <= r_rd_cnt + 1'b1;
            if (w_cmd == CmdWr && r_wr_cnt != '1)     r_wr_cnt  <= r_wr_cnt + 1'b1;
            if (w_is_ref && r_ref_cnt != '1)          r_ref_cnt <= r_ref_cnt + 1'b1;
         end
      end
   end

   assign bank_open_o  = w_open;
   assign err_valid_o  = r_err_valid;
   assign err_code_o   = r_err_code;
   assign err_bank_o   = r_err_bank;
   assign err_sticky_o = r_sticky;
   assign act_cnt_o    = r_act_cnt;
   assign rd_cnt_o     = r_rd_cnt;
   assign wr_cnt_o     = r_wr_cnt;
   assign ref_cnt_o    = r_ref_cnt;

endmodule
